// File: rtl/core_pkg.sv
// Shared core-wide constants and the fetch packet type.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch packets; entry 0 is always the head. Flush beats push.
module fetch_skid_fifo
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  input  logic       flush,
  output fetch_pkt_t head,
  output logic [1:0] occ
);

  fetch_pkt_t ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0] occ_q, occ_d;

  // Next-state for entries and occupancy; entries shift toward the head on pop.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            ent0_d = push_pkt;
            occ_d  = 2'd1;
          end else if (occ_q == 2'd1) begin
            ent1_d = push_pkt;
            occ_d  = 2'd2;
          end
        end
        2'b01: begin
          if (occ_q != 2'd0) begin
            ent0_d = ent1_q;
            occ_d  = occ_q - 2'd1;
          end
        end
        2'b11: begin
          // Occupancy is unchanged unless the FIFO was empty (pop then is a no-op).
          if (occ_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = push_pkt;
          end else begin
            ent0_d = push_pkt;
            occ_d  = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head = ent0_q;
  assign occ  = occ_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch initiator: drives the sync-read ROM address, absorbs its 1-cycle latency and
// presents {pc, inst} to decode over valid/ready, with redirect flush.
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [1:0]      occ;
  logic            pop, issue;
  logic [2:0]      demand, limit;
  fetch_pkt_t      head, push_pkt;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign out_valid = (occ != 2'd0) && !redirect_valid;
  assign pop       = out_valid && out_ready;

  // Issue only if the FIFO can absorb everything already owed to it plus this request.
  assign demand = {1'b0, occ} + {2'b00, inflight_q};
  assign limit  = 3'd1 + {2'b00, pop};
  assign issue  = !redirect_valid && (demand <= limit);

  assign push_pkt = '{pc: inflight_pc_q, inst: imem_inst};

  fetch_skid_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_pkt (push_pkt),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (head),
    .occ      (occ)
  );

  // Next fetch address and in-flight tracking; redirect overrides issue.
  always_comb begin
    addr_d        = addr_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      addr_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = addr_q;
      addr_d        = addr_q + XLEN'(INST_BYTES);
    end
  end

  // Fetch state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      addr_q        <= addr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign imem_addr = addr_q;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: ROM model plus an in-order pc stream model.
module tb_instruction_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int          checks;
  int          failures;
  logic [31:0] exp_pc;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read ROM: data for the address sampled at an edge appears after it.
  always @(posedge clk) imem_inst <= rom_word(imem_addr);

  task automatic test_reset;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++;
    if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
    checks++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0) begin
      failures++; $display("FAIL reset_out got=%h/%h want=0/0", out_pc, out_inst);
    end
    rst = 1'b0;
    exp_pc = 32'h0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL release_c1 got valid=%b addr=%h want 0/4", out_valid, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== rom_word(exp_pc)) begin
      failures++;
      $display("FAIL release_c2 got v=%b pc=%h inst=%h want 1/%h/%h",
               out_valid, out_pc, out_inst, exp_pc, rom_word(exp_pc));
    end
    exp_pc += 4;
  endtask

  // Steady streaming with out_ready held high: one instruction every cycle.
  task automatic test_stream(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== rom_word(exp_pc)) begin
        failures++;
        $display("FAIL stream got v=%b pc=%h inst=%h want 1/%h/%h",
                 out_valid, out_pc, out_inst, exp_pc, rom_word(exp_pc));
      end
      checks++;
      if (imem_addr !== exp_pc + 32'd8) begin
        failures++; $display("FAIL stream_addr got=%h want=%h", imem_addr, exp_pc + 32'd8);
      end
      exp_pc += 4;
    end
  endtask

  task automatic test_backpressure;
    int xfers;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_addr !== exp_pc + 32'd8) begin
        failures++; $display("FAIL bp_addr_hold got=%h want=%h", imem_addr, exp_pc + 32'd8);
      end
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== rom_word(exp_pc)) begin
        failures++;
        $display("FAIL bp_head got v=%b pc=%h inst=%h want 1/%h/%h",
                 out_valid, out_pc, out_inst, exp_pc, rom_word(exp_pc));
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== rom_word(exp_pc)) begin
        failures++;
        $display("FAIL bp_resume got v=%b pc=%h inst=%h want 1/%h/%h",
                 out_valid, out_pc, out_inst, exp_pc, rom_word(exp_pc));
      end
      exp_pc += 4;
    end
    // Random backpressure: head must always be the next pc in sequence.
    xfers = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid) begin
        checks++;
        if (out_pc !== exp_pc || out_inst !== rom_word(exp_pc)) begin
          failures++;
          $display("FAIL bp_rand got pc=%h inst=%h want %h/%h",
                   out_pc, out_inst, exp_pc, rom_word(exp_pc));
        end
        if (out_ready) begin
          exp_pc += 4;
          xfers++;
        end
      end
    end
    checks++;
    if (xfers < 20) begin failures++; $display("FAIL bp_progress got=%0d want>=20", xfers); end
  endtask

  task automatic test_redirect(input logic [31:0] rpc, input logic [31:0] target);
    @(posedge clk); #1 out_ready = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = rpc;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b want=0", out_valid); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_addr !== target || out_valid !== 1'b0) begin
      failures++; $display("FAIL redir_k1 got addr=%h v=%b want %h/0", imem_addr, out_valid, target);
    end
    @(negedge clk);
    checks++;
    if (imem_addr !== target + 32'd4 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_k2 got addr=%h v=%b want %h/0", imem_addr, out_valid, target + 32'd4);
    end
    exp_pc = target;
    test_stream(4);
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_first got=%b want=0", out_valid); end
    @(posedge clk); #1 redirect_pc = 32'h200;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b want=0", out_valid); end
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'h200) begin failures++; $display("FAIL b2b_addr got=%h want=200", imem_addr); end
    @(negedge clk);
    exp_pc = 32'h200;
    test_stream(3);
  endtask

  task automatic test_random;
    int xfers;
    xfers = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      @(negedge clk);
      if (redirect_valid) begin
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rand_redir_valid got=%b", out_valid); end
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (out_valid) begin
        checks++;
        if (out_pc !== exp_pc || out_inst !== rom_word(exp_pc)) begin
          failures++;
          $display("FAIL rand_stream got pc=%h inst=%h want %h/%h",
                   out_pc, out_inst, exp_pc, rom_word(exp_pc));
        end
        if (out_ready) begin
          exp_pc += 4;
          xfers++;
        end
      end
    end
    @(posedge clk); #1 redirect_valid = 1'b0;
    checks++;
    if (xfers < 50) begin failures++; $display("FAIL rand_progress got=%0d want>=50", xfers); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0 || out_pc !== 32'h0) begin
      failures++;
      $display("FAIL async_rst got v=%b addr=%h pc=%h want 0/0/0", out_valid, imem_addr, out_pc);
    end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    exp_pc = 32'h0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h4) begin
      failures++; $display("FAIL rerelease_c1 got v=%b addr=%h want 0/4", out_valid, imem_addr);
    end
    test_stream(5);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_stream(20);
    test_backpressure();
    test_redirect(32'h40, 32'h40);
    test_redirect(32'h47, 32'h44);
    test_redirect(32'hFFFF_FFFC, 32'hFFFF_FFFC);
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
